mcu_mem_responder: RTL
======================

Name: mcu_mem_responder

Overview:
- Memory-side responder to the main control unit's read/write request interface.
- Accepts one-cycle o_re/o_we strobes with 32-bit addresses from the control unit and performs the access on a fixed-latency synchronous SRAM port.
- Returns one-cycle read-complete and write-complete pulses, plus captured read data.
- Sits between the control unit and the image frame memory; the complete pulses close the control unit's read and write wait loops.

Parameters:
- DATA_W, 32, width of read/write data words
- MEM_DEPTH, 480000, number of valid word addresses; addresses >= MEM_DEPTH are out of range
- RD_LAT, 2, cycles from mem read enable to valid i_mem_rdata (1..7)
- WR_LAT, 1, cycles a write must be held off before completion (1..7)

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- i_re  in  1  read request strobe (1 cycle)
- i_raddr  in  32  read address, valid with i_re
- i_we  in  1  write request strobe (1 cycle)
- i_waddr  in  32  write address, valid with i_we
- i_wdata  in  DATA_W  write data, valid with i_we
- o_read_complete  out  1  1-cycle pulse, read finished
- o_rdata  out  DATA_W  last read data, held until next read completes
- o_write_complete  out  1  1-cycle pulse, write finished
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_addr_err  out  1  sticky out-of-range flag
- o_overrun  out  1  sticky dropped-request flag
- o_mem_addr  out  32  SRAM address
- o_mem_ren  out  1  SRAM read enable
- o_mem_wen  out  1  SRAM write enable
- o_mem_wdata  out  DATA_W  SRAM write data
- i_mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is synchronous and active-low. All outputs are registered.
- Reset values:
  - All outputs 0, including o_rdata, o_mem_addr and both sticky flags.
  - FSM in IDLE; pending registers empty.
- Reset asserted mid-access: the access is abandoned, and no complete pulse is generated.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_DONE, WR_ISSUE, WR_WAIT, WR_DONE.
- Request capture (every cycle, in any state):
  - i_re latches i_raddr into the read-pending register.
  - i_we latches i_waddr and i_wdata into the write-pending register.
  - One pending slot per type. If a new request arrives while that slot is already full, the request is dropped, o_overrun is set, and the existing slot is not modified.
- IDLE transitions:
  - Go to WR_ISSUE if a write is pending (writes have priority).
  - Otherwise go to RD_ISSUE if a read is pending.
  - A request sampled in cycle T is issued in cycle T+1.
- RD_ISSUE: o_mem_ren=1 and o_mem_addr=address for exactly one cycle (cycle N); clears the read slot.
- RD_WAIT:
  - Counts RD_LAT cycles.
  - i_mem_rdata is captured into o_rdata at the end of cycle N+RD_LAT.
- RD_DONE: o_read_complete=1 in cycle N+RD_LAT+1, then go to IDLE.
- Read end-to-end: i_re at T gives o_read_complete at T+2+RD_LAT (T+4 at default).
- WR_ISSUE: o_mem_wen=1 with o_mem_addr and o_mem_wdata for one cycle (cycle N); clears the write slot.
- WR_WAIT: counts WR_LAT cycles.
- WR_DONE: o_write_complete=1 in cycle N+WR_LAT+1, then go to IDLE.
- Out-of-range address (addr >= MEM_DEPTH):
  - No SRAM enable is asserted, and o_addr_err is set (sticky until reset).
  - The FSM still traverses the wait states, so latency is unchanged and the complete pulse still fires.
  - For a read, o_rdata is loaded with 0.
- Simultaneous i_re and i_we: both slots are loaded; the write is served first and the read follows immediately.
- Bus idle values: o_mem_ren and o_mem_wen are 0 outside the ISSUE states. o_mem_addr and o_mem_wdata hold their last values.
- Complete pulses: never both high in the same cycle; never longer than 1 cycle.

Optional Feature:
- Macro: MCU_MEM_STATS_EN.
- When defined:
  - Adds ports o_rd_count (out, 16) and o_wr_count (out, 16). Both reset to 0.
  - Each increments on its complete pulse, including out-of-range accesses, and saturates at 16'hFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single read: i_re with i_raddr=0x10 at T, i_mem_rdata=0xA5A5_0001 at N+2 -> o_mem_ren at T+1 with addr 0x10; o_read_complete at T+4; o_rdata=0xA5A5_0001; o_busy high T+1..T+4.
- Single write: i_we with addr 599, data 0x0000_00FF -> o_mem_wen at T+1 with addr 599 and data 0xFF; o_write_complete at T+3.
- Simultaneous i_re (addr 5) and i_we (addr 6) -> write issued first (wen at T+1), read issued at T+4; write_complete at T+3; read_complete at T+7.
- Out-of-range read at addr 480000 -> no o_mem_ren; o_read_complete at T+4; o_rdata=0; o_addr_err=1 and stays 1.
- Three reads at T, T+1, T+2 while busy -> second is held in the pending slot and served; third is dropped; o_overrun=1; exactly two read_complete pulses.
- n_rst low during RD_WAIT -> next cycle all outputs 0, state IDLE, no complete pulse; with MCU_MEM_STATS_EN, counters are 0.

Source files
------------

// File: rtl/mcu_mem_responder.sv
// Memory-side responder for the main control unit's read/write request strobes.
// Captures one-cycle requests into single-entry pending slots, performs the access
// on a fixed-latency synchronous SRAM port and returns one-cycle complete pulses.
// Writes take priority over reads. Out-of-range addresses skip the SRAM enable
// but keep the normal latency.
// Optional feature: define MCU_MEM_STATS_EN to add saturating completion counters.
module mcu_mem_responder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 480000,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_re,
  input  logic [31:0]       i_raddr,
  input  logic              i_we,
  input  logic [31:0]       i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_read_complete,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_write_complete,
  output logic              o_busy,
  output logic              o_addr_err,
  output logic              o_overrun,
`ifdef MCU_MEM_STATS_EN
  output logic [15:0]       o_rd_count,
  output logic [15:0]       o_wr_count,
`endif
  output logic [31:0]       o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [31:0] DepthW = 32'(MEM_DEPTH);
  localparam logic [2:0]  RdLatW = 3'(RD_LAT);
  localparam logic [2:0]  WrLatW = 3'(WR_LAT);

  typedef enum logic [2:0] {
    StIdle, StRdIssue, StRdWait, StRdDone, StWrIssue, StWrWait, StWrDone
  } state_e;

  state_e              state;
  logic                rd_valid;
  logic [31:0]         rd_addr;
  logic                wr_valid;
  logic [31:0]         wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_oor;
  logic [2:0]          lat_cnt;

  logic                dispatch;
  logic                issue_wr;
  logic                issue_rd;
  logic [31:0]         wr_sel_addr;
  logic [31:0]         rd_sel_addr;
  logic [DATA_W-1:0]   wr_sel_data;
  logic                wr_sel_oor;
  logic                rd_sel_oor;

  // Dispatch selection: a full slot is served before a same-cycle incoming request,
  // and the DONE states dispatch too so back-to-back accesses lose no cycle.
  always_comb begin
    dispatch    = (state == StIdle) || (state == StRdDone) || (state == StWrDone);
    issue_wr    = dispatch && (wr_valid || i_we);
    issue_rd    = dispatch && !issue_wr && (rd_valid || i_re);
    wr_sel_addr = wr_valid ? wr_addr : i_waddr;
    wr_sel_data = wr_valid ? wr_data : i_wdata;
    rd_sel_addr = rd_valid ? rd_addr : i_raddr;
    wr_sel_oor  = (wr_sel_addr >= DepthW);
    rd_sel_oor  = (rd_sel_addr >= DepthW);
  end

  // Request capture, access FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state            <= StIdle;
      rd_valid         <= 1'b0;
      rd_addr          <= '0;
      wr_valid         <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      rd_oor           <= 1'b0;
      lat_cnt          <= '0;
      o_read_complete  <= 1'b0;
      o_rdata          <= '0;
      o_write_complete <= 1'b0;
      o_busy           <= 1'b0;
      o_addr_err       <= 1'b0;
      o_overrun        <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_ren        <= 1'b0;
      o_mem_wen        <= 1'b0;
      o_mem_wdata      <= '0;
`ifdef MCU_MEM_STATS_EN
      o_rd_count       <= '0;
      o_wr_count       <= '0;
`endif
    end else begin
      o_mem_ren        <= 1'b0;
      o_mem_wen        <= 1'b0;
      o_read_complete  <= 1'b0;
      o_write_complete <= 1'b0;

      // A request meeting a full slot is dropped, even if that slot drains this cycle.
      if ((i_we && wr_valid) || (i_re && rd_valid)) o_overrun <= 1'b1;

      if (issue_wr) begin
        wr_valid <= 1'b0;
      end else if (i_we && !wr_valid) begin
        wr_valid <= 1'b1;
        wr_addr  <= i_waddr;
        wr_data  <= i_wdata;
      end

      if (issue_rd) begin
        rd_valid <= 1'b0;
      end else if (i_re && !rd_valid) begin
        rd_valid <= 1'b1;
        rd_addr  <= i_raddr;
      end

      unique case (state)
        StIdle, StRdDone, StWrDone: begin
          if (issue_wr) begin
            state       <= StWrIssue;
            o_busy      <= 1'b1;
            o_mem_wen   <= !wr_sel_oor;
            o_mem_addr  <= wr_sel_addr;
            o_mem_wdata <= wr_sel_data;
            if (wr_sel_oor) o_addr_err <= 1'b1;
          end else if (issue_rd) begin
            state      <= StRdIssue;
            o_busy     <= 1'b1;
            o_mem_ren  <= !rd_sel_oor;
            o_mem_addr <= rd_sel_addr;
            rd_oor     <= rd_sel_oor;
            if (rd_sel_oor) o_addr_err <= 1'b1;
          end else begin
            state  <= StIdle;
            o_busy <= 1'b0;
          end
        end
        StRdIssue: begin
          state   <= StRdWait;
          lat_cnt <= 3'd1;
        end
        StRdWait: begin
          if (lat_cnt == RdLatW) begin
            state           <= StRdDone;
            o_rdata         <= rd_oor ? '0 : i_mem_rdata;
            o_read_complete <= 1'b1;
`ifdef MCU_MEM_STATS_EN
            if (o_rd_count != 16'hFFFF) o_rd_count <= o_rd_count + 16'd1;
`endif
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        StWrIssue: begin
          state   <= StWrWait;
          lat_cnt <= 3'd1;
        end
        StWrWait: begin
          if (lat_cnt == WrLatW) begin
            state            <= StWrDone;
            o_write_complete <= 1'b1;
`ifdef MCU_MEM_STATS_EN
            if (o_wr_count != 16'hFFFF) o_wr_count <= o_wr_count + 16'd1;
`endif
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: begin
          state  <= StIdle;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
